// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one single-port unified memory between fetch and data requesters.
// Define MEM_ARB_STARVE_GUARD_EN to let fetch win after STARVE_MAX consecutive data grants.
module cpu_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  state_t     state_r;
  logic [3:0] lat_cnt_r;
  logic       owner_d_r;
  logic       owner_we_r;
  logic       pick_d_s;
  logic       issue_s;
  logic       done_s;

  // Outputs are forced low whenever reset is held, regardless of state.
  assign issue_s = reset && (state_r == IDLE) && (if_req || d_req);
  assign done_s  = reset && (state_r == WAIT) && (lat_cnt_r == 4'd0);

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_r;
  logic       starve_hit_s;

  assign starve_hit_s = (starve_r == 4'(STARVE_MAX));

  // Winner selection: data first unless fetch has been passed over STARVE_MAX times.
  always_comb begin
    pick_d_s = 1'b0;
    if (d_req) begin
      if (if_req && starve_hit_s) begin
        pick_d_s = 1'b0;
      end else begin
        pick_d_s = 1'b1;
      end
    end else begin
      pick_d_s = 1'b0;
    end
  end

  // Starvation counter: counts data grants taken while fetch is waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_r <= 4'd0;
    end else if (issue_s && !pick_d_s) begin
      starve_r <= 4'd0;
    end else if ((state_r == IDLE) && !if_req) begin
      starve_r <= 4'd0;
    end else if (issue_s && pick_d_s && if_req && (starve_r != 4'hF)) begin
      starve_r <= starve_r + 4'd1;
    end
  end
`else
  // Winner selection: strict data priority.
  always_comb begin
    pick_d_s = 1'b0;
    if (d_req) begin
      pick_d_s = 1'b1;
    end else begin
      pick_d_s = 1'b0;
    end
  end
`endif

  // Issue path: drive the memory with the winner's request in the grant cycle.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = {DW{1'b0}};
    if (issue_s) begin
      mem_en = 1'b1;
      if (pick_d_s) begin
        d_gnt     = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else begin
        if_gnt   = 1'b1;
        mem_addr = if_addr;
      end
    end else begin
      mem_en = 1'b0;
    end
  end

  // Response path: route mem_rdata only to the owner, and only on its valid cycle.
  always_comb begin
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = {DW{1'b0}};
    d_rdata   = {DW{1'b0}};
    if (done_s) begin
      if (owner_d_r) begin
        d_rvalid = 1'b1;
        if (owner_we_r) begin
          d_rdata = {DW{1'b0}};
        end else begin
          d_rdata = mem_rdata;
        end
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
    end else begin
      if_rvalid = 1'b0;
    end
  end

  // Access FSM: latch the owner at issue, then count down the memory latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      lat_cnt_r  <= 4'd0;
      owner_d_r  <= 1'b0;
      owner_we_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (issue_s) begin
            state_r    <= WAIT;
            lat_cnt_r  <= LAT_LOAD;
            owner_d_r  <= pick_d_s;
            owner_we_r <= pick_d_s & d_we;
          end
        end
        WAIT: begin
          if (lat_cnt_r == 4'd0) begin
            state_r <= IDLE;
          end else begin
            lat_cnt_r <= lat_cnt_r - 4'd1;
          end
        end
        default: begin
          state_r   <= IDLE;
          lat_cnt_r <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: instance a uses MEM_LAT=1, instance b uses MEM_LAT=3.
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_pass = 0;
  int          n_total = 0;

  logic        a_if_req, a_if_gnt, a_if_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
  logic        a_mem_en, a_mem_we;
  logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
  logic        b_mem_en, b_mem_we;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  logic [31:0] mem_a [16] = '{0: 32'h0022_1800, 1: 32'd55, default: 32'h0};
  logic [31:0] mem_b [16] = '{0: 32'h1111_0000, 1: 32'd100, default: 32'h0};
  logic [31:0] a_rd_q, b_p0, b_p1, b_p2;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) u_a (
    .clk(clk), .reset(rst_n),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid),
    .if_rdata(a_if_rdata), .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr),
    .d_wdata(a_d_wdata), .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata)
  );

  cpu_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) u_b (
    .clk(clk), .reset(rst_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
    .if_rdata(b_if_rdata), .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr),
    .d_wdata(b_d_wdata), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  // Memory models; idle read data is junk so un-gated rdata paths show up.
  always @(posedge clk) begin
    if (a_mem_en && a_mem_we) mem_a[a_mem_addr[5:2]] <= a_mem_wdata;
    a_rd_q <= (a_mem_en && !a_mem_we) ? mem_a[a_mem_addr[5:2]] : 32'hDEAD_BEEF;
    if (b_mem_en && b_mem_we) mem_b[b_mem_addr[5:2]] <= b_mem_wdata;
    b_p0 <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr[5:2]] : 32'hDEAD_BEEF;
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign a_mem_rdata = a_rd_q;
  assign b_mem_rdata = b_p2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    logic exp_d, exp_i;
    rst_n = 1'b0;
    a_if_req = 1'b1; a_d_req = 1'b1; a_d_we = 1'b0; a_if_addr = 32'h0; a_d_addr = 32'h4;
    a_d_wdata = 32'h0;
    b_if_req = 1'b1; b_d_req = 1'b1; b_d_we = 1'b0; b_if_addr = 32'h0; b_d_addr = 32'h4;
    b_d_wdata = 32'h0;
    smp();
    chk("rst_a_if_gnt", {31'd0, a_if_gnt}, 32'd0);
    chk("rst_a_d_gnt", {31'd0, a_d_gnt}, 32'd0);
    chk("rst_a_mem_en", {31'd0, a_mem_en}, 32'd0);
    chk("rst_a_mem_addr", a_mem_addr, 32'd0);
    chk("rst_b_d_gnt", {31'd0, b_d_gnt}, 32'd0);
    chk("rst_b_mem_en", {31'd0, b_mem_en}, 32'd0);
    nxt();
    a_if_req = 1'b0; a_d_req = 1'b0; b_if_req = 1'b0; b_d_req = 1'b0;
    rst_n = 1'b1;
    smp();

    // Fetch only, latency 1
    nxt(); a_if_req = 1'b1; a_if_addr = 32'h0;
    smp();
    chk("t1_if_gnt_T", {31'd0, a_if_gnt}, 32'd1);
    chk("t1_mem_en_T", {31'd0, a_mem_en}, 32'd1);
    chk("t1_mem_we_T", {31'd0, a_mem_we}, 32'd0);
    chk("t1_rvalid_T", {31'd0, a_if_rvalid}, 32'd0);
    nxt(); smp();
    chk("t1_if_gnt_T1", {31'd0, a_if_gnt}, 32'd0);
    chk("t1_rvalid_T1", {31'd0, a_if_rvalid}, 32'd1);
    chk("t1_rdata_T1", a_if_rdata, 32'h0022_1800);
    chk("t1_d_rvalid_T1", {31'd0, a_d_rvalid}, 32'd0);
    nxt(); smp();
    chk("t1_if_gnt_T2", {31'd0, a_if_gnt}, 32'd1);
    chk("t1_rdata_T2", a_if_rdata, 32'd0);
    nxt(); a_if_req = 1'b0;
    smp();
    chk("t1_rdata_T3", a_if_rdata, 32'h0022_1800);
    nxt(); smp();
    chk("t1_idle_mem_en", {31'd0, a_mem_en}, 32'd0);

    // Both held high: data priority (or guard hand-over)
    nxt(); a_if_req = 1'b1; a_d_req = 1'b1; a_d_addr = 32'h4; a_d_we = 1'b0;
    for (int k = 0; k < 10; k++) begin
      smp();
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_d = (k % 2 == 0) && (k < 8);
      exp_i = (k == 8);
`else
      exp_d = (k % 2 == 0);
      exp_i = 1'b0;
`endif
      chk($sformatf("t4_d_gnt_%0d", k), {31'd0, a_d_gnt}, {31'd0, exp_d});
      chk($sformatf("t4_if_gnt_%0d", k), {31'd0, a_if_gnt}, {31'd0, exp_i});
      nxt();
    end
    a_if_req = 1'b0; a_d_req = 1'b0;
    smp();

    // Load latency 3, fetch blocked until the load completes
    nxt(); b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h4; b_if_req = 1'b1; b_if_addr = 32'h0;
    smp();
    chk("t2_d_gnt_T", {31'd0, b_d_gnt}, 32'd1);
    chk("t2_if_gnt_T", {31'd0, b_if_gnt}, 32'd0);
    chk("t2_mem_addr_T", b_mem_addr, 32'h4);
    nxt(); b_d_req = 1'b0;
    smp();
    chk("t2_if_gnt_T1", {31'd0, b_if_gnt}, 32'd0);
    chk("t2_mem_en_T1", {31'd0, b_mem_en}, 32'd0);
    nxt(); smp();
    chk("t2_d_rvalid_T2", {31'd0, b_d_rvalid}, 32'd0);
    nxt(); smp();
    chk("t2_d_rvalid_T3", {31'd0, b_d_rvalid}, 32'd1);
    chk("t2_d_rdata_T3", b_d_rdata, 32'd100);
    chk("t2_if_gnt_T3", {31'd0, b_if_gnt}, 32'd0);
    chk("t2_if_rdata_T3", b_if_rdata, 32'd0);
    nxt(); smp();
    chk("t2_if_gnt_T4", {31'd0, b_if_gnt}, 32'd1);
    nxt(); b_if_req = 1'b0;
    smp(); nxt(); smp(); nxt(); smp();
    chk("t2_if_rvalid_T7", {31'd0, b_if_rvalid}, 32'd1);
    chk("t2_if_rdata_T7", b_if_rdata, 32'h1111_0000);
    chk("t2_d_rdata_T7", b_d_rdata, 32'd0);

    // Store then load back
    nxt(); b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = 32'h8; b_d_wdata = 32'd100;
    smp();
    chk("t3_mem_we_T", {31'd0, b_mem_we}, 32'd1);
    chk("t3_mem_addr_T", b_mem_addr, 32'h8);
    chk("t3_mem_wdata_T", b_mem_wdata, 32'd100);
    nxt(); b_d_req = 1'b0;
    smp(); nxt(); smp(); nxt(); smp();
    chk("t3_st_rvalid", {31'd0, b_d_rvalid}, 32'd1);
    chk("t3_st_rdata", b_d_rdata, 32'd0);
    nxt(); b_d_req = 1'b1; b_d_we = 1'b0;
    smp();
    chk("t3_ld_gnt", {31'd0, b_d_gnt}, 32'd1);
    nxt(); b_d_req = 1'b0;
    smp(); nxt(); smp(); nxt(); smp();
    chk("t3_ld_rvalid", {31'd0, b_d_rvalid}, 32'd1);
    chk("t3_ld_rdata", b_d_rdata, 32'd100);

    // Data request dropped while fetch in flight
    nxt(); b_if_req = 1'b1; b_if_addr = 32'h0;
    smp();
    chk("t6_if_gnt_T", {31'd0, b_if_gnt}, 32'd1);
    nxt(); b_if_req = 1'b0; b_d_req = 1'b1; b_d_addr = 32'h4;
    smp();
    chk("t6_d_gnt_T1", {31'd0, b_d_gnt}, 32'd0);
    nxt(); b_d_req = 1'b0;
    smp();
    chk("t6_d_gnt_T2", {31'd0, b_d_gnt}, 32'd0);
    nxt(); b_d_req = 1'b1;
    smp();
    chk("t6_d_gnt_T3", {31'd0, b_d_gnt}, 32'd0);
    chk("t6_if_rvalid_T3", {31'd0, b_if_rvalid}, 32'd1);
    nxt(); smp();
    chk("t6_d_gnt_T4", {31'd0, b_d_gnt}, 32'd1);
    nxt(); b_d_req = 1'b0;
    smp(); nxt(); smp(); nxt(); smp();
    chk("t6_d_rdata_T7", b_d_rdata, 32'd100);

    // Reset during the WAIT of a load aborts it
    nxt(); b_d_req = 1'b1; b_d_addr = 32'h4;
    smp();
    chk("t5_d_gnt_T", {31'd0, b_d_gnt}, 32'd1);
    nxt(); b_d_req = 1'b0; b_if_req = 1'b1; b_if_addr = 32'h0;
    smp();
    chk("t5_if_gnt_T1", {31'd0, b_if_gnt}, 32'd0);
    nxt(); rst_n = 1'b0;
    smp();
    chk("t5_rst_if_gnt", {31'd0, b_if_gnt}, 32'd0);
    chk("t5_rst_mem_en", {31'd0, b_mem_en}, 32'd0);
    nxt(); rst_n = 1'b1;
    smp();
    chk("t5_rel_if_gnt", {31'd0, b_if_gnt}, 32'd1);
    chk("t5_rel_d_rvalid", {31'd0, b_d_rvalid}, 32'd0);
    chk("t5_rel_d_rdata", b_d_rdata, 32'd0);
    nxt(); b_if_req = 1'b0;
    smp(); nxt(); smp(); nxt(); smp();
    chk("t5_if_rvalid", {31'd0, b_if_rvalid}, 32'd1);
    chk("t5_if_rdata", b_if_rdata, 32'h1111_0000);
    chk("t5_d_rvalid_end", {31'd0, b_d_rvalid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
